sr_latch_driver: RTL and testbench

Clocked front end that drives the S and R inputs of the gate-level SR latch from two raw push-button inputs. It synchronises and debounces each button, and turns each debounced press into one fixed-width S or R pulse. It never asserts S and R together. After each pulse it checks the latch's Q/Qbar feedback against the expected state. It sits directly upstream of the SR latch and consumes that latch's outputs.

---
 rtl/sr_pkg.sv | 17 +
 rtl/btn_conditioner.sv | 49 ++++
 rtl/sr_latch_driver.sv | 133 +++++++++++++
 tb/tb_sr_latch_driver.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and helpers for the SR latch driver slice.
package sr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PULSE_S,
    PULSE_R,
    GAP,
    CHECK
  } sr_state_t;

  // Counter width able to hold the value n itself.
  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Synchronises, debounces and rise-detects one raw push button.
module btn_conditioner
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int CW = CNT_W(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // A new level is only accepted once it has been seen DEBOUNCE_CYCLES times in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      level     <= 1'b0;
      level_d   <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= btn;
      sync_q    <= sync_meta;
      level_d   <= level;
      if (sync_q != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_q;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/sr_latch_driver.sv
// Turns debounced set/reset button presses into non-overlapping S/R pulses
// and checks the latch feedback after each command.
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int GAP_CYCLES      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic reset_btn,
  input  logic Q,
  input  logic Qbar,
  output logic S,
  output logic R,
  output logic q_exp,
  output logic busy,
  output logic fault
);

  localparam int CW = CNT_W((PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  sr_state_t     state;
  sr_state_t     state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          req_s;
  logic          req_r;
  logic          pend_s;
  logic          pend_r;
  logic          load_set;
  logic          load_rst;
  logic          check_now;
  logic          mismatch;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_btn (
    .clk   (clk),
    .reset (reset),
    .btn   (set_btn),
    .rise  (req_s)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_btn (
    .clk   (clk),
    .reset (reset),
    .btn   (reset_btn),
    .rise  (req_r)
  );

  // Reset wins over set when both are pending; the losing set request is dropped.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    load_set  = 1'b0;
    load_rst  = 1'b0;
    check_now = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (pend_r) begin
          state_nx = PULSE_R;
          load_rst = 1'b1;
        end else if (pend_s) begin
          state_nx = PULSE_S;
          load_set = 1'b1;
        end
      end
      PULSE_S, PULSE_R: begin
        if (cnt == PULSE_LAST) begin
          state_nx = GAP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = CHECK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      CHECK: begin
        check_now = 1'b1;
        state_nx  = IDLE;
        cnt_nx    = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign mismatch = (Q != q_exp) || (Q == Qbar);

  // S/R come straight from the next state so they can never overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      S      <= 1'b0;
      R      <= 1'b0;
      q_exp  <= 1'b0;
      fault  <= 1'b0;
      pend_s <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      S     <= (state_nx == PULSE_S);
      R     <= (state_nx == PULSE_R);
      if (load_set) begin
        q_exp <= 1'b1;
      end else if (load_rst) begin
        q_exp <= 1'b0;
      end
      if (check_now && mismatch) begin
        fault <= 1'b1;
      end
      pend_s <= (pend_s & (state != IDLE)) | req_s;
      pend_r <= (pend_r & (state != IDLE)) | req_r;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: vector table, corner sequences and random buttons vs. a command-level model.
module tb_sr_latch_driver;

  localparam int DEB = 4;
  localparam int PW  = 2;
  localparam int GW  = 2;
  localparam logic [31:0] MASK = (32'd1 << DEB) - 32'd1;

  logic clk = 1'b0;
  logic reset;
  logic set_btn;
  logic reset_btn;
  logic Q;
  logic Qbar;
  logic S;
  logic R;
  logic q_exp;
  logic busy;
  logic fault;
  logic q_latch = 1'b0;
  logic force_bad = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_no   = 0;

  always #5 clk = ~clk;

  // Behavioural latch hanging off the driver outputs
  always @(posedge S or posedge R) q_latch <= S ? 1'b1 : 1'b0;

  assign Q    = force_bad ? 1'b0 : q_latch;
  assign Qbar = force_bad ? 1'b0 : ~q_latch;

  sr_latch_driver #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PW),
    .GAP_CYCLES     (GW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .set_btn   (set_btn),
    .reset_btn (reset_btn),
    .Q         (Q),
    .Qbar      (Qbar),
    .S         (S),
    .R         (R),
    .q_exp     (q_exp),
    .busy      (busy),
    .fault     (fault)
  );

  // Reference model: index 0 is the set button, 1 the reset button
  logic        m_sync1 [2];
  logic        m_sync2 [2];
  logic        m_deb   [2];
  logic        m_deb_d [2];
  logic        m_pend  [2];
  logic [31:0] m_hist  [2];
  int          m_phase;
  logic        m_cmd_s;
  logic        m_qexp, m_fault, m_q, m_s, m_r, m_busy;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_sync1[b] = 1'b0;
      m_sync2[b] = 1'b0;
      m_deb[b]   = 1'b0;
      m_deb_d[b] = 1'b0;
      m_pend[b]  = 1'b0;
      m_hist[b]  = '0;
    end
    m_phase = 0;
    m_cmd_s = 1'b0;
    m_qexp  = 1'b0;
    m_fault = 1'b0;
    m_s     = 1'b0;
    m_r     = 1'b0;
    m_busy  = 1'b0;
  endtask

  // One command occupies phases 1..PW (pulse), PW+1..PW+GW (gap), PW+GW+1 (check)
  task automatic model_step();
    logic req [2];
    logic raw;
    logic qin, qbin;
    bit   idle;
    for (int b = 0; b < 2; b++) req[b] = m_deb[b] & ~m_deb_d[b];
    qin  = force_bad ? 1'b0 : m_q;
    qbin = force_bad ? 1'b0 : ~m_q;
    idle = (m_phase == 0);
    if (idle) begin
      if (m_pend[1]) begin
        m_phase = 1; m_cmd_s = 1'b0; m_qexp = 1'b0;
      end else if (m_pend[0]) begin
        m_phase = 1; m_cmd_s = 1'b1; m_qexp = 1'b1;
      end
    end else if (m_phase == PW + GW + 1) begin
      if (qin !== m_qexp || qin === qbin) m_fault = 1'b1;
      m_phase = 0;
    end else begin
      m_phase++;
    end
    for (int b = 0; b < 2; b++) m_pend[b] = (idle ? 1'b0 : m_pend[b]) | req[b];
    m_s    = (m_phase >= 1) && (m_phase <= PW) && m_cmd_s;
    m_r    = (m_phase >= 1) && (m_phase <= PW) && !m_cmd_s;
    m_busy = (m_phase != 0);
    if (m_s) m_q = 1'b1;
    else if (m_r) m_q = 1'b0;
    for (int b = 0; b < 2; b++) begin
      raw       = (b == 0) ? set_btn : reset_btn;
      m_hist[b] = {m_hist[b][30:0], m_sync2[b]};
      m_deb_d[b] = m_deb[b];
      if ((m_hist[b] & MASK) == (m_deb[b] ? 32'd0 : MASK)) m_deb[b] = ~m_deb[b];
      m_sync2[b] = m_sync1[b];
      m_sync1[b] = raw;
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc_no, act, exp);
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic checkOutput();
    checkBit("S", S, m_s);
    checkBit("R", R, m_r);
    checkBit("q_exp", q_exp, m_qexp);
    checkBit("busy", busy, m_busy);
    checkBit("fault", fault, m_fault);
    checkBit("S_and_R", S & R, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc_no++;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic sb, input logic rb, input logic bad);
    set_btn   = sb;
    reset_btn = rb;
    force_bad = bad;
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    force_bad = 1'b0;
    model_reset();
    #1;
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] set_pat;
    logic [31:0] rst_pat;
    logic        bad;
    int          s_cyc;
    int          r_cyc;
    int          first_edge;
    int          gap;
    logic        qexp;
    logic        flt;
    logic        any_busy;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int s_n, r_n, first, gap, low;
    bit seen, busy_seen;
    int pulses;

    reset     = 1'b1;
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    //             set_pat       rst_pat       bad  S  R  first gap qexp flt busy
    vecs[0] = '{32'h000F_FFFF, 32'h0000_0000, 1'b0, 2, 0, 7, -1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_0005, 32'h0000_0000, 1'b0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h000F_FFFF, 32'h000F_FFFF, 1'b0, 0, 2, 7, -1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h000F_FFFF, 32'h001F_FFFE, 1'b0, 2, 2, 7, 4, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h000F_FFFF, 32'h0000_0000, 1'b1, 2, 0, 7, -1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h000F_FFFF, 1'b0, 0, 2, 7, -1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0007, 32'h0000_0007, 1'b0, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h0000_000F, 1'b0, 0, 2, 7, -1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 8; i++) begin
      do_reset();
      s_n = 0; r_n = 0; first = -1; gap = -1; low = 0; seen = 0; busy_seen = 0;
      for (int c = 0; c < 40; c++) begin
        applyStimulus((c < 32) ? vecs[i].set_pat[c] : 1'b0,
                      (c < 32) ? vecs[i].rst_pat[c] : 1'b0, vecs[i].bad);
        if (S) s_n++;
        if (R) r_n++;
        if ((S | R) && first < 0) first = c;
        if (S | R) begin
          if (seen && low > 0) gap = low;
          seen = 1;
          low  = 0;
        end else begin
          low++;
        end
        if (busy) busy_seen = 1;
      end
      checkInt($sformatf("row%0d_S_cycles", i), s_n, vecs[i].s_cyc);
      checkInt($sformatf("row%0d_R_cycles", i), r_n, vecs[i].r_cyc);
      checkInt($sformatf("row%0d_first_edge", i), first, vecs[i].first_edge);
      checkInt($sformatf("row%0d_low_gap", i), gap, vecs[i].gap);
      checkBit($sformatf("row%0d_q_exp", i), q_exp, vecs[i].qexp);
      checkBit($sformatf("row%0d_fault", i), fault, vecs[i].flt);
      checkBit($sformatf("row%0d_busy_seen", i), busy_seen, vecs[i].any_busy);
    end

    // Bad feedback sets fault, and later good commands do not clear it
    do_reset();
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b1);
    checkBit("fault_after_bad_check", fault, 1'b1);
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);
    checkBit("fault_sticky", fault, 1'b1);
    checkBit("fault_sticky_q_exp", q_exp, 1'b0);
    do_reset();
    checkBit("fault_cleared_by_reset", fault, 1'b0);

    // Reset in the second PULSE_R cycle, with a set request already pending
    do_reset();
    for (int c = 0; c < 9; c++) applyStimulus(c >= 2, 1'b1, 1'b0);
    checkBit("R_second_pulse_cycle", R, 1'b1);
    reset     = 1'b1;
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    model_reset();
    #1;
    checkBit("async_R_drop", R, 1'b0);
    checkBit("async_S_low", S, 1'b0);
    checkBit("async_q_exp", q_exp, 1'b0);
    checkBit("async_busy", busy, 1'b0);
    checkBit("async_fault", fault, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (S | R) pulses++;
    end
    checkInt("no_pulse_after_reset", pulses, 0);

    // Random buttons with bounces, long holds, occasional bad feedback and resets
    begin
      int   hold [2];
      logic lvl  [2];
      hold[0] = 0; hold[1] = 0; lvl[0] = 1'b0; lvl[1] = 1'b0;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
        for (int b = 0; b < 2; b++) begin
          if (hold[b] == 0) begin
            lvl[b]  = 1'($urandom_range(0, 1));
            hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 25))
                                                   : int'($urandom_range(1, 6));
          end
          hold[b]--;
        end
        if ($urandom_range(0, 299) == 0) force_bad = ~force_bad;
        applyStimulus(lvl[0], lvl[1], force_bad);
        if ((c % 800) == 799) begin
          do_reset();
          hold[0] = 0; hold[1] = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
